baud_cfg_ctrl: RTL and testbench
================================

// Module: baud_cfg_ctrl
// PURPOSE
//   Owns the baud generator's divisor and enable inputs. Captures divisor writes from the register
//   block into a shadow register and applies them only when TX and RX are quiescent.
//   Runs a disable -> load -> hold -> re-enable sequence so no bclk is generated from a half-updated count.
//   Sits between the AHB register file and baud_generator inside the UART core.
// PARAMETERS
//   DIV_W       16    divisor width; must match the baud generator
//   DEF_DIV     325   divisor driven out of reset
//   HOLD_CYC    2     cycles bg_enable is held low after a new divisor is loaded (min 1)
//   TIMEOUT_CYC 4096  PEND cycles before a forced apply (used only with BAUD_CFG_TIMEOUT_EN)
// PORTS
//   clk         in   1      system clock
//   reset       in   1      asynchronous, active-high reset
//   cfg_en      in   1      UART enable from control register
//   cfg_wr      in   1      one-cycle divisor write strobe
//   cfg_div     in   DIV_W  divisor value accompanying cfg_wr
//   tx_busy     in   1      transmitter shifting a frame
//   rx_busy     in   1      receiver inside a frame
//   div_out     out  DIV_W  divisor to baud generator
//   bg_enable   out  1      enable to baud generator
//   cfg_pending out  1      a write is accepted but not yet applied
//   cfg_ack     out  1      one-cycle pulse: divisor applied, or write was a no-op
//   div_err     out  1      one-cycle pulse: cfg_div==0 rejected
//   cfg_forced  out  1      one-cycle pulse: apply forced by timeout (tied 0 without macro)
// BEHAVIOUR
//   Reset values: div_out=DEF_DIV, shadow=DEF_DIV, bg_enable=0, cfg_pending=0, pulses=0, state=RUN.
//   States: RUN, PEND, APPLY, HOLD. All outputs are registered.
//   RUN: bg_enable=cfg_en. All cfg_wr outcomes below take effect 1 cycle after the strobe:
//     - cfg_div==0: div_err pulses; shadow, state and div_out are unchanged.
//     - cfg_div==div_out: cfg_ack pulses; no state change.
//     - otherwise: shadow<=cfg_div, cfg_pending<=1, ->PEND.
//   PEND: bg_enable=cfg_en. A new nonzero cfg_wr overwrites shadow (last write wins).
//     A zero write pulses div_err and keeps the old shadow.
//     ->APPLY in the first cycle where (!tx_busy && !rx_busy) || !cfg_en.
//   APPLY (1 cycle): bg_enable<=0, div_out<=shadow ->HOLD.
//   HOLD: bg_enable=0 for HOLD_CYC cycles, then ->RUN.
//     On exit: cfg_pending<=0, cfg_ack pulses, bg_enable<=cfg_en.
//   cfg_wr during APPLY/HOLD (nonzero, != shadow): captured into shadow, cfg_pending stays 1,
//     and HOLD exits to PEND instead of RUN. No cfg_ack is issued for the superseded value.
//   Simultaneous cfg_wr and busy deassertion in PEND: the new value is used; the write wins the same cycle.
//   cfg_en falling in any state: bg_enable=0 next cycle; the sequence continues.
//   Reset mid-sequence: everything returns to reset values; the pending write is discarded.
//   Apply-to-ack latency from the quiescent cycle: 1 (APPLY) + HOLD_CYC + 1.
// CONFIGURATION
//   BAUD_CFG_TIMEOUT_EN defined: a PEND cycle counter cleared on PEND entry and on every cfg_wr.
//     At TIMEOUT_CYC the block goes ->APPLY regardless of busy, and cfg_forced pulses with cfg_ack.
//   Not defined: no counter; PEND waits indefinitely; cfg_forced=0.
// STRUCTURE
//   Package baud_cfg_pkg: state enum {RUN,PEND,APPLY,HOLD}, DIV_W, DEF_DIV, and a HOLD counter width
//     function (clog2).
//   One sub-module: baud_cfg_timer (loadable down-counter with done flag). It is shared by the HOLD
//     count and, under the macro, the PEND timeout; each is loaded on its state entry.
// TESTING
//   Reset release -> div_out=325, bg_enable=0, then bg_enable=1 the cycle after cfg_en=1.
//   Idle UART, cfg_wr cfg_div=27 -> cfg_pending 1; div_out=27 and bg_enable=0 for 3 cycles;
//     cfg_ack 4 cycles after PEND.
//   tx_busy=1 for 500 cycles, writes 27 then 54 -> div_out stays 325 until busy drops,
//     then becomes 54; single cfg_ack.
//   cfg_wr cfg_div=0 -> div_err pulse, div_out unchanged, no cfg_pending;
//     write equal to div_out -> cfg_ack only.
//   Reset asserted in HOLD -> div_out=325, cfg_pending=0, bg_enable=0 asynchronously.
//   With BAUD_CFG_TIMEOUT_EN, TIMEOUT_CYC=16, rx_busy stuck 1 -> apply after 16 PEND cycles,
//     cfg_forced and cfg_ack pulse together.

Source files
------------

// File: rtl/baud_cfg_pkg.sv
// rtl/baud_cfg_pkg.sv - shared types and constants for the baud configuration controller
// Contents:
//   DIV_W, DEF_DIV : default divisor width and reset divisor
//   st_e           : sequencer states RUN, PEND, APPLY, HOLD
//   cnt_w()        : bits needed by a down-counter that is loaded with n-1
package baud_cfg_pkg;

  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 325;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } st_e;

  // Smallest width able to hold n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/baud_cfg_timer.sv
// rtl/baud_cfg_timer.sv - loadable down-counter with done flag
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : W-bit start value
//   done       : counter has reached zero
module baud_cfg_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/baud_cfg_ctrl.sv
// rtl/baud_cfg_ctrl.sv - divisor shadowing and safe apply sequencing for the baud generator
// Optional feature macro: BAUD_CFG_TIMEOUT_EN (forced apply after TIMEOUT_CYC PEND cycles)
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   cfg_en               : UART enable
//   cfg_wr, cfg_div      : one-cycle divisor write strobe and value
//   tx_busy, rx_busy     : TX / RX inside a frame
//   div_out, bg_enable   : divisor and enable to the baud generator
//   cfg_pending          : accepted write not yet applied
//   cfg_ack              : pulse, divisor applied or write was a no-op
//   div_err              : pulse, zero divisor rejected
//   cfg_forced           : pulse with cfg_ack when the apply was forced by timeout
module baud_cfg_ctrl #(
  parameter int DIV_W       = baud_cfg_pkg::DIV_W,
  parameter int DEF_DIV     = baud_cfg_pkg::DEF_DIV,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic [DIV_W-1:0] div_out,
  output logic             bg_enable,
  output logic             cfg_pending,
  output logic             cfg_ack,
  output logic             div_err,
  output logic             cfg_forced
);

  import baud_cfg_pkg::*;

  localparam int TMR_W = cnt_w((HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [TMR_W-1:0] HOLD_VAL  = TMR_W'(HOLD_CYC - 1);

  st_e              state, state_n;
  logic [DIV_W-1:0] shadow, shadow_d, div_d;
  logic             pend_d, ack_d, err_d, bg_d;
  logic             rearm, rearm_d;
  logic             wr_nz, wr_zero, quiet, capture, hold_exit, ack_exit, timeout;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  assign wr_zero = cfg_wr && (cfg_div == '0);
  assign wr_nz   = cfg_wr && (cfg_div != '0);
  // A disabled UART has nothing in flight, so it counts as quiescent.
  assign quiet   = (!tx_busy && !rx_busy) || !cfg_en;
  // A write landing while a value is being applied re-arms the sequence.
  assign capture   = ((state == APPLY) || (state == HOLD)) && wr_nz && (cfg_div != shadow);
  assign hold_exit = (state == HOLD) && tmr_done;
  assign ack_exit  = hold_exit && !(rearm || capture);

`ifdef BAUD_CFG_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_VAL = TMR_W'(TIMEOUT_CYC - 1);
  // A write in the same cycle restarts the wait instead of timing out.
  assign timeout = (state == PEND) && tmr_done && !cfg_wr;
`else
  assign timeout = 1'b0;
`endif

  baud_cfg_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      div_out     <= DEF_DIV_V;
      shadow      <= DEF_DIV_V;
      bg_enable   <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_ack     <= 1'b0;
      div_err     <= 1'b0;
      rearm       <= 1'b0;
    end else begin
      state       <= state_n;
      div_out     <= div_d;
      shadow      <= shadow_d;
      bg_enable   <= bg_d;
      cfg_pending <= pend_d;
      cfg_ack     <= ack_d;
      div_err     <= err_d;
      rearm       <= rearm_d;
    end
  end

  // Next state.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (wr_nz && (cfg_div != div_out)) state_n = PEND;
      PEND:    if (quiet || timeout) state_n = APPLY;
      APPLY:   state_n = HOLD;
      HOLD:    if (tmr_done) state_n = (rearm || capture) ? PEND : RUN;
      default: state_n = RUN;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    shadow_d = shadow;
    div_d    = div_out;
    pend_d   = cfg_pending;
    ack_d    = 1'b0;
    err_d    = wr_zero;
    rearm_d  = 1'b0;
    bg_d     = ((state_n == RUN) || (state_n == PEND)) ? cfg_en : 1'b0;
    case (state)
      RUN: begin
        if (wr_nz) begin
          if (cfg_div == div_out) begin
            ack_d = 1'b1;
          end else begin
            shadow_d = cfg_div;
            pend_d   = 1'b1;
          end
        end
      end
      PEND: begin
        if (wr_nz) shadow_d = cfg_div;
        // shadow_d already carries a same-cycle write, so the newest value is applied.
        if (state_n == APPLY) div_d = shadow_d;
      end
      APPLY, HOLD: begin
        if (capture) shadow_d = cfg_div;
        rearm_d = (rearm || capture) && !hold_exit;
        if (ack_exit) begin
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The shared timer counts HOLD from APPLY, and the PEND timeout from PEND entry or a write.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_VAL;
    if (state == APPLY) begin
      tmr_load = 1'b1;
    end
`ifdef BAUD_CFG_TIMEOUT_EN
    else if ((state_n == PEND) && ((state != PEND) || cfg_wr)) begin
      tmr_load = 1'b1;
      tmr_val  = TO_VAL;
    end
`endif
  end

`ifdef BAUD_CFG_TIMEOUT_EN
  logic forced_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      forced_q   <= 1'b0;
      cfg_forced <= 1'b0;
    end else begin
      cfg_forced <= ack_exit && forced_q;
      if ((state == PEND) && (state_n == APPLY)) begin
        forced_q <= !quiet;
      end else if (hold_exit) begin
        forced_q <= 1'b0;
      end
    end
  end
`else
  assign cfg_forced = 1'b0;
`endif

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb/tb_baud_cfg_ctrl.sv - randomized self-checking bench for baud_cfg_ctrl
module tb_baud_cfg_ctrl;

  localparam int HOLD_CYC = 2;
`ifdef BAUD_CFG_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;
`else
  localparam int TIMEOUT_CYC = 4096;
`endif

  logic        clk;
  logic        reset;
  logic        cfg_en;
  logic        cfg_wr;
  logic [15:0] cfg_div;
  logic        tx_busy;
  logic        rx_busy;
  logic [15:0] div_out;
  logic        bg_enable;
  logic        cfg_pending;
  logic        cfg_ack;
  logic        div_err;
  logic        cfg_forced;

  baud_cfg_ctrl #(
    .DIV_W       (16),
    .DEF_DIV     (325),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_en      (cfg_en),
    .cfg_wr      (cfg_wr),
    .cfg_div     (cfg_div),
    .tx_busy     (tx_busy),
    .rx_busy     (rx_busy),
    .div_out     (div_out),
    .bg_enable   (bg_enable),
    .cfg_pending (cfg_pending),
    .cfg_ack     (cfg_ack),
    .div_err     (div_err),
    .cfg_forced  (cfg_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: applied divisor, latest requested divisor, and how many
  // cycles of the no-clock window (apply + hold) remain.
  int m_div, m_shadow, m_window, m_waited;
  bit m_pend, m_waiting, m_again, m_fflag;
  bit m_bg, m_ack, m_err, m_forced;

  function automatic void model_reset();
    m_div = 325; m_shadow = 325; m_window = 0; m_waited = 0;
    m_pend = 0; m_waiting = 0; m_again = 0; m_fflag = 0;
    m_bg = 0; m_ack = 0; m_err = 0; m_forced = 0;
  endfunction

  function automatic void model_step();
    bit nz, idle, fire;
    int d;
    d      = int'(cfg_div);
    nz     = cfg_wr && (d != 0);
    idle   = (!tx_busy && !rx_busy) || !cfg_en;
    fire   = 0;
    m_err  = cfg_wr && (d == 0);
    m_ack  = 0;
    m_forced = 0;
    if (m_window > 0) begin
      if (nz && d != m_shadow) begin
        m_shadow = d;
        m_again  = 1;
      end
      m_window--;
      if (m_window == 0) begin
        if (m_again) begin
          m_again = 0; m_waiting = 1; m_waited = 0;
        end else begin
          m_pend = 0; m_ack = 1; m_forced = m_fflag;
        end
        m_fflag = 0;
      end
    end else if (m_waiting) begin
      if (nz) m_shadow = d;
`ifdef BAUD_CFG_TIMEOUT_EN
      if (cfg_wr) m_waited = 0;
      else m_waited++;
      fire = (m_waited >= TIMEOUT_CYC);
`endif
      if (idle || fire) begin
        m_div = m_shadow;
        m_waiting = 0;
        m_fflag = !idle;
        m_window = 1 + HOLD_CYC;
      end
    end else if (nz) begin
      if (d == m_div) begin
        m_ack = 1;
      end else begin
        m_shadow = d; m_pend = 1; m_waiting = 1; m_waited = 0;
      end
    end
    m_bg = (m_window > 0) ? 1'b0 : cfg_en;
  endfunction

  task automatic compare_all();
    check("div_out", div_out, m_div);
    check("bg_enable", bg_enable, m_bg);
    check("cfg_pending", cfg_pending, m_pend);
    check("cfg_ack", cfg_ack, m_ack);
    check("div_err", div_err, m_err);
    check("cfg_forced", cfg_forced, m_forced);
  endtask

  task automatic tick(input bit wr, input int d, input bit en, input bit tx, input bit rx);
    cfg_wr  = wr;
    cfg_div = 16'(d);
    cfg_en  = en;
    tx_busy = tx;
    rx_busy = rx;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called just after a tick; reset is pulsed between clock edges.
  task automatic do_reset();
    cfg_wr = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_div_out", div_out, 325);
    check("rst_pending", cfg_pending, 0);
    check("rst_bg_enable", bg_enable, 0);
    #3 reset = 1'b0;
  endtask

  int ack_at, forced_at, bg_low, acks;
  bit busy_r, en_r;

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_wr = 1'b0; cfg_div = '0;
    tx_busy = 1'b0; rx_busy = 1'b0;
    model_reset();
    #2;
    compare_all();
    #10 reset = 1'b0;

    // Enable follows cfg_en one cycle later.
    tick(0, 0, 0, 0, 0);
    check("bg_off_when_disabled", bg_enable, 0);
    tick(0, 0, 1, 0, 0);
    check("bg_on_after_en", bg_enable, 1);

    // Idle apply of 27.
    tick(1, 27, 1, 0, 0);
    check("pend_after_wr", cfg_pending, 1);
    ack_at = -1; bg_low = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(0, 0, 1, 0, 0);
      if (cfg_ack && ack_at < 0) ack_at = i;
      if (!bg_enable) bg_low++;
    end
    check("idle_ack_latency", ack_at, 4);
    check("idle_bg_low_cycles", bg_low, 3);
    check("idle_div_27", div_out, 27);

    // Long busy with two writes: only the last one is applied, once.
    do_reset();
    acks = 0;
    tick(1, 27, 1, 1, 0);
    for (int i = 0; i < 499; i++) begin
      tick(i == 100, 54, 1, 1, 0);
      if (cfg_ack) acks++;
    end
`ifndef BAUD_CFG_TIMEOUT_EN
    check("busy_div_held", div_out, 325);
`endif
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 0, 0);
      if (cfg_ack) acks++;
    end
`ifndef BAUD_CFG_TIMEOUT_EN
    check("busy_single_ack", acks, 1);
`endif
    check("busy_div_54", div_out, 54);

    // Zero write rejected, equal write acknowledged only.
    tick(1, 0, 1, 0, 0);
    check("zero_err", div_err, 1);
    check("zero_no_pend", cfg_pending, 0);
    tick(1, 54, 1, 0, 0);
    check("equal_ack", cfg_ack, 1);
    check("equal_no_pend", cfg_pending, 0);

    // Reset while in HOLD.
    tick(1, 99, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    check("hold_div_99", div_out, 99);
    do_reset();
    tick(0, 0, 1, 0, 0);

`ifdef BAUD_CFG_TIMEOUT_EN
    // Stuck receiver: apply forced after TIMEOUT_CYC PEND cycles.
    tick(1, 27, 1, 0, 1);
    ack_at = -1; forced_at = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(0, 0, 1, 0, 1);
      if (cfg_ack && ack_at < 0) ack_at = i;
      if (cfg_forced && forced_at < 0) forced_at = i;
    end
    check("timeout_ack_at", ack_at, TIMEOUT_CYC + HOLD_CYC + 1);
    check("timeout_forced_at", forced_at, TIMEOUT_CYC + HOLD_CYC + 1);
    do_reset();
`endif

    // Randomized traffic.
    busy_r = 0; en_r = 1;
    for (int n = 0; n < 4000; n++) begin
      int r, d;
      bit wr;
      if ($urandom_range(0, 19) == 0) busy_r = !busy_r;
      if ($urandom_range(0, 99) == 0) en_r = !en_r;
      wr = ($urandom_range(0, 4) == 0);
      r  = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r <= 2) d = m_div;
      else if (r == 3) d = m_shadow;
      else             d = $urandom_range(1, 8) * 10;
      tick(wr, d, en_r, busy_r && $urandom_range(0, 1) == 1, busy_r);
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
